// File: rtl/sha256_pkg.sv
// SHA-256 constants, fixed padding of the 640-bit message and the round helper functions.
package sha256_pkg;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // W4..W15: end-of-message marker, zero fill, bit length 640
   localparam logic [383:0] PAD = {32'h80000000, 320'h0, 32'h00000280};

   // wv[7]=a .. wv[0]=h; win[15] is the word consumed by the current round
   typedef struct packed {
      logic [7:0][31:0]  wv;
      logic [15:0][31:0] win;
      logic [7:0][31:0]  mid;
   } state_t;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_round_stage.sv
// One pipeline stage: registered working state plus one combinational round and schedule step.
module sha256_round_stage
   import sha256_pkg::*;
#(
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [5:0]       k_idx,
   input  state_t           src,
   input  logic [TAG_W-1:0] src_tag,
   input  logic             src_valid,
   output state_t           nxt,
   output logic [TAG_W-1:0] tag,
   output logic             valid
);

   state_t      st;
   logic [31:0] t1;
   logic [31:0] t2;
   logic [31:0] w_new;

   assign t1    = st.wv[0] + big_sigma1(st.wv[3]) + ch(st.wv[3], st.wv[2], st.wv[1]) + K[k_idx] + st.win[15];
   assign t2    = big_sigma0(st.wv[7]) + maj(st.wv[7], st.wv[6], st.wv[5]);
   assign w_new = small_sigma1(st.win[1]) + st.win[6] + small_sigma0(st.win[14]) + st.win[15];

   always_comb begin
      nxt     = st;
      nxt.wv  = {t1 + t2, st.wv[7], st.wv[6], st.wv[5], st.wv[4] + t1, st.wv[3], st.wv[2], st.wv[1]};
      nxt.win = {st.win[14:0], w_new};
   end

   // load takes the predecessor's result; otherwise the stage folds its own round back in
   always_ff @(posedge clk) begin
      if (load) begin
         st  <= src;
         tag <= src_tag;
      end else begin
         st  <= nxt;
      end
      if (!rst)
         valid <= 1'b0;
      else if (load)
         valid <= src_valid;
   end

endmodule

// File: rtl/sha256_folded_pipeline.sv
// Second-chunk SHA-256 over a 640-bit message, 64/FOLD stages each running FOLD rounds per job.
module sha256_folded_pipeline
   import sha256_pkg::*;
#(
   parameter int FOLD  = 1,
   parameter int TAG_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [255:0]     digest_in,
   input  logic [127:0]     block_in,
   input  logic [TAG_W-1:0] tag_in,
   output logic [255:0]     digest_out,
   output logic             valid_out,
   output logic [TAG_W-1:0] tag_out
);

   localparam int NS = 64 / FOLD;
   localparam int PW = (FOLD > 1) ? $clog2(FOLD) : 1;

   if (FOLD != 1 && FOLD != 2 && FOLD != 4 && FOLD != 8 && FOLD != 16 && FOLD != 32 && FOLD != 64) begin : g_bad_fold
      $error("sha256_folded_pipeline: FOLD must be 1, 2, 4, 8, 16, 32 or 64");
   end

   logic [PW-1:0]    phase;
   logic             shift;
   state_t           src_st    [NS];
   state_t           out_st    [NS];
   logic [TAG_W-1:0] src_tag   [NS];
   logic [TAG_W-1:0] tag_q     [NS];
   logic             src_valid [NS];
   logic             valid_q   [NS];
   logic [7:0][31:0] final_sum;

   assign shift    = (phase == PW'(FOLD - 1));
   assign in_ready = shift;

   always_ff @(posedge CLK) begin
      if (!RST || shift)
         phase <= '0;
      else
         phase <= phase + 1'b1;
   end

   for (genvar s = 0; s < NS; s++) begin : g_stage
      if (s == 0) begin : g_head
         assign src_st[s]    = '{wv: digest_in, win: {block_in, PAD}, mid: digest_in};
         assign src_tag[s]   = tag_in;
         assign src_valid[s] = in_valid;
      end else begin : g_link
         assign src_st[s]    = out_st[s-1];
         assign src_tag[s]   = tag_q[s-1];
         assign src_valid[s] = valid_q[s-1];
      end

      sha256_round_stage #(.TAG_W(TAG_W)) u_stage (
         .clk       (CLK),
         .rst       (RST),
         .load      (shift),
         .k_idx     (6'(s * FOLD) + 6'(phase)),
         .src       (src_st[s]),
         .src_tag   (src_tag[s]),
         .src_valid (src_valid[s]),
         .nxt       (out_st[s]),
         .tag       (tag_q[s]),
         .valid     (valid_q[s])
      );
   end

   always_comb begin
      final_sum = '0;
      for (int unsigned i = 0; i < 8; i++)
         final_sum[i] = out_st[NS-1].mid[i] + out_st[NS-1].wv[i];
   end

   // the last stage finishes round 63 in the cycle its shift edge arrives
   always_ff @(posedge CLK) begin
      if (!RST) begin
         valid_out  <= 1'b0;
         digest_out <= '0;
         tag_out    <= '0;
      end else begin
         valid_out <= shift && valid_q[NS-1];
         if (shift && valid_q[NS-1]) begin
            digest_out <= final_sum;
            tag_out    <= tag_q[NS-1];
         end
      end
   end

endmodule

// File: tb/tb_sha256_folded_pipeline.sv
// Scoreboard bench driving FOLD=1, FOLD=4 and FOLD=64 instances with known 640-bit message vectors.
module tb_sha256_folded_pipeline;

   localparam logic [255:0] MID   = 256'hF59007B57A2E5616B8F47922F4A62AA5F6F596588185BBAEFA09E7763BC75771;
   localparam logic [127:0] BLK_A = 128'h252db801130dae516461011a3aeb9bb8;
   localparam logic [127:0] BLK_B = 128'h252db801111111112222222233333333;
   localparam logic [127:0] BLK_C = 128'h252db801444444445555555566666666;
   localparam logic [255:0] DIG_A = 256'hDB9E1922353D832D0158CFEB6C16048BE029A92DA694B3620D053FD675377467;
   localparam logic [255:0] DIG_B = 256'hCC2C548F92AD138966F49C583141736125D5553890A78A5B7D07F89E5604C586;
   localparam logic [255:0] DIG_C = 256'h54138AEB12BE9864C0E574122007A04F1A951629E582CBBA6C3CB14111EE6D35;

   typedef struct {
      int          id;
      int          due;
      logic [255:0] dig;
      logic [31:0]  tag;
   } exp_t;

   logic         CLK = 1'b0;
   logic         RST;
   logic [2:0]   iv;
   logic [2:0]   rdy;
   logic [2:0]   vout;
   logic [255:0] din;
   logic [127:0] blk;
   logic [31:0]  tin;
   logic [255:0] dout [3];
   logic [31:0]  tout [3];

   exp_t         sb [$];
   int           cyc = 0;
   int           vectors = 0;
   int           miscompares = 0;
   int           ph [3];
   logic [255:0] last_dig [3];
   logic [31:0]  last_tag [3];
   logic [255:0] cur_exp;
   bit           mon_en = 1'b0;

   always #5 CLK = ~CLK;

   sha256_folded_pipeline #(.FOLD(1), .TAG_W(32)) u_f1 (
      .CLK(CLK), .RST(RST), .in_valid(iv[0]), .in_ready(rdy[0]), .digest_in(din), .block_in(blk),
      .tag_in(tin), .digest_out(dout[0]), .valid_out(vout[0]), .tag_out(tout[0]));

   sha256_folded_pipeline #(.FOLD(4), .TAG_W(32)) u_f4 (
      .CLK(CLK), .RST(RST), .in_valid(iv[1]), .in_ready(rdy[1]), .digest_in(din), .block_in(blk),
      .tag_in(tin), .digest_out(dout[1]), .valid_out(vout[1]), .tag_out(tout[1]));

   sha256_folded_pipeline #(.FOLD(64), .TAG_W(32)) u_f64 (
      .CLK(CLK), .RST(RST), .in_valid(iv[2]), .in_ready(rdy[2]), .digest_in(din), .block_in(blk),
      .tag_in(tin), .digest_out(dout[2]), .valid_out(vout[2]), .tag_out(tout[2]));

   function automatic int fold_of(input int i);
      case (i)
         0:       return 1;
         1:       return 4;
         default: return 64;
      endcase
   endfunction

   // accept bookkeeping: a job taken at this edge must appear 64 edges later
   always @(posedge CLK) begin
      cyc++;
      if (!RST) begin
         sb.delete();
         for (int i = 0; i < 3; i++) begin
            ph[i]       = 0;
            last_dig[i] = '0;
            last_tag[i] = '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (iv[i] && rdy[i])
               sb.push_back('{id: i, due: cyc + 64, dig: cur_exp, tag: tin});
            ph[i] = (ph[i] + 1) % fold_of(i);
         end
      end
   end

   always @(negedge CLK) begin
      if (mon_en) begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            assert (rdy[i] === (ph[i] == fold_of(i) - 1)) else begin
               miscompares++;
               $error("FAIL in_ready dut%0d cyc=%0d observed=%b expected=%b", i, cyc, rdy[i], (ph[i] == fold_of(i) - 1));
            end
            if (sb.size() > 0 && sb[0].id == i && sb[0].due <= cyc) begin
               exp_t e;
               e = sb.pop_front();
               vectors++;
               assert (vout[i] === 1'b1 && e.due == cyc) else begin
                  miscompares++;
                  $error("FAIL valid_out dut%0d cyc=%0d observed=%b expected=1 at cyc %0d", i, cyc, vout[i], e.due);
               end
               vectors++;
               assert (dout[i] === e.dig) else begin
                  miscompares++;
                  $error("FAIL digest_out dut%0d cyc=%0d observed=%h expected=%h", i, cyc, dout[i], e.dig);
               end
               vectors++;
               assert (tout[i] === e.tag) else begin
                  miscompares++;
                  $error("FAIL tag_out dut%0d cyc=%0d observed=%0d expected=%0d", i, cyc, tout[i], e.tag);
               end
               last_dig[i] = e.dig;
               last_tag[i] = e.tag;
            end else begin
               vectors++;
               assert (vout[i] === 1'b0 && dout[i] === last_dig[i] && tout[i] === last_tag[i]) else begin
                  miscompares++;
                  $error("FAIL idle_hold dut%0d cyc=%0d observed v=%b d=%h t=%0d expected v=0 d=%h t=%0d",
                         i, cyc, vout[i], dout[i], tout[i], last_dig[i], last_tag[i]);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_job(input logic [127:0] b, input logic [255:0] d, input logic [31:0] t);
      blk     = b;
      cur_exp = d;
      tin     = t;
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && sb.size() > 0; n++)
         tick();
      repeat (4) tick();
   endtask

   initial begin
      RST = 1'b0;
      iv  = '0;
      din = MID;
      set_job(BLK_A, DIG_A, 0);
      repeat (3) tick();
      RST    = 1'b1;
      mon_en = 1'b1;

      // single job on FOLD=1
      set_job(BLK_A, DIG_A, 1);
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      drain();

      // three back-to-back jobs
      iv[0] = 1'b1;
      set_job(BLK_A, DIG_A, 2);
      tick();
      set_job(BLK_B, DIG_B, 3);
      tick();
      set_job(BLK_C, DIG_C, 4);
      tick();
      iv[0] = 1'b0;
      drain();

      // bubbles on two of five ready cycles
      iv[0] = 1'b1; set_job(BLK_A, DIG_A, 5);  tick();
      iv[0] = 1'b0; set_job(BLK_B, DIG_B, 99); tick();
      iv[0] = 1'b1; set_job(BLK_B, DIG_B, 6);  tick();
      iv[0] = 1'b0; set_job(BLK_C, DIG_C, 98); tick();
      iv[0] = 1'b1; set_job(BLK_C, DIG_C, 7);  tick();
      iv[0] = 1'b0;
      drain();

      // reset 30 cycles into a job, then a fresh job
      set_job(BLK_A, DIG_A, 8);
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      repeat (30) tick();
      RST = 1'b0;
      tick();
      RST = 1'b1;
      repeat (100) tick();
      set_job(BLK_B, DIG_B, 9);
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      drain();

      // FOLD=4 with in_valid held: one accept every 4 cycles
      iv[1] = 1'b1;
      for (int n = 0; n < 16; n++) begin
         set_job(BLK_A, DIG_A, 32'(10 + n));
         tick();
      end
      iv[1] = 1'b0;
      drain();

      // FOLD=64 single stage with in_valid held across two ready slots
      iv[2] = 1'b1;
      for (int n = 0; n < 140; n++) begin
         set_job(BLK_C, DIG_C, 32'(40 + n));
         tick();
      end
      iv[2] = 1'b0;
      drain();

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sha256_folded_pipeline.md
SHA256_FOLDED_PIPELINE -- requirements
Module: sha256_folded_pipeline

Interface
REQ-001 The block SHALL have parameter FOLD, default 1: rounds executed per pipeline stage; legal values 1,2,4,8,16,32,64.
REQ-002 The block SHALL have parameter TAG_W, default 32: width of the job tag carried alongside each hash (nonce id).
REQ-003 CLK  input  1  sole clock; all state on rising edge.
REQ-004 RST  input  1  reset; synchronous, active-low.
REQ-005 in_valid  input  1  a job is presented this cycle.
REQ-006 in_ready  output  1  block accepts a job this cycle.
REQ-007 digest_in  input  256  midstate H0..H7 (H0 in [255:224]); both the round-0 working state and the final addend.
REQ-008 block_in  input  128  message words W0..W3 of the second chunk (W0 in [127:96]).
REQ-009 tag_in  input  TAG_W  job tag.
REQ-010 digest_out  output  256  H'0..H'7, same packing as digest_in.
REQ-011 valid_out  output  1  one-cycle pulse per completed job.
REQ-012 tag_out  output  TAG_W  tag of the job on digest_out.

Function
REQ-013 W4..W15 SHALL be fixed padding for a 640-bit message: W4=32'h80000000, W5..W14=0, W15=32'h00000280.
REQ-014 The pipeline SHALL have NS=64/FOLD stages. Each stage holds: a..h, a 16-word schedule window, digest_in copy, tag, valid bit.
REQ-015 A phase counter SHALL count 0..FOLD-1 and wrap; for FOLD=1 it is constant 0.
REQ-016 Each cycle, stage s SHALL compute round k=s*FOLD+phase with K[k] and W[k]; W[k] for k>=16 comes from the standard sigma0/sigma1 schedule update of the window.
REQ-017 phase<FOLD-1: each stage SHALL write its round result back into itself. phase==FOLD-1: each stage SHALL shift its result into stage s+1; the last stage's result goes to the final adder.
REQ-018 in_ready SHALL equal (phase==FOLD-1) and SHALL be independent of in_valid.
REQ-019 When in_valid && in_ready, stage 0 SHALL load a..h=digest_in, window=W0..W15, tag, valid=1. When in_ready && !in_valid, stage 0 SHALL load valid=0 (bubble). in_valid while !in_ready SHALL be ignored; no data is lost for a source that holds it.
REQ-020 The final adder SHALL register digest_out = carried digest_in + a..h, per 32-bit word mod 2^32.
REQ-021 Latency: a job accepted in cycle t SHALL produce valid_out=1 in cycle t+65, for every FOLD.
REQ-022 Throughput SHALL be one job per FOLD cycles; there is no output backpressure.
REQ-023 digest_out and tag_out SHALL hold their last value while valid_out=0.
REQ-024 Bubbles SHALL propagate as valid=0 and never raise valid_out.
REQ-025 An illegal FOLD SHALL stop elaboration with an error.

Reset
REQ-026 While RST=0 at a rising edge: phase=0, all stage valid bits=0, valid_out=0, digest_out=0, tag_out=0. Datapath stage registers need no reset.
REQ-027 Reset mid-flight SHALL discard every in-flight job; none of them may raise valid_out after reset.
REQ-028 The first cycle after reset SHALL have in_ready=(FOLD==1).

Structure
REQ-029 A shared package sha256_pkg SHALL hold: K[0..63], the padding words, and the Ch/Maj/Sigma0/Sigma1/sigma0/sigma1 functions.
REQ-030 One sub-module, sha256_round_stage (one round plus schedule step, registered stage state), SHALL be instantiated NS times via generate.

Verification
REQ-031 FOLD=1, digest_in=F59007B57A2E5616B8F47922F4A62AA5F6F596588185BBAEFA09E7763BC75771, block_in=252db801130dae516461011a3aeb9bb8, tag=1 -> exactly 65 cycles later: valid_out=1, digest_out=DB9E1922353D832D0158CFEB6C16048BE029A92DA694B3620D053FD675377467, tag_out=1.
REQ-032 FOLD=1, back-to-back block_in ...130dae516461011a3aeb9bb8, 252db801111111112222222233333333, 252db801444444445555555566666666 (same midstate) -> three consecutive valid_out cycles: DB9E...7467, then CC2C548F92AD138966F49C583141736125D5553890A78A5B7D07F89E5604C586, then 54138AEB12BE9864C0E574122007A04F1A951629E582CBBA6C3CB14111EE6D35.
REQ-033 FOLD=4, in_valid held high with the REQ-031 vector -> in_ready high 1 cycle in 4; first result 65 cycles after the first accept; then valid_out every 4th cycle, each DB9E...7467.
REQ-034 FOLD=1, in_valid low on 2 of 5 ready cycles -> valid_out pattern 1,0,1,0,1 starting at cycle +65, tags in order.
REQ-035 FOLD=1, RST=0 for 1 cycle 30 cycles after an accept -> valid_out stays 0 for 100 cycles; a job accepted after reset returns the correct digest at +65.
REQ-036 FOLD=64 (single stage), REQ-031 vector -> same digest at +65; in_ready high once every 64 cycles.
